// File: rtl/key_scanner.sv
// key_scanner: eight push-buttons, synchronized and debounced one counter per key.
// Each clean level change is queued as a press/release event for the consumer.
module key_scanner #(
   parameter int DEBOUNCE_CYCLES = 59500,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] btn_raw,
   output logic [7:0] btn,
   output logic       note_active,
   output logic [2:0] note_idx,
   output logic       event_valid,
   input  logic       event_ready,
   output logic [2:0] event_key,
   output logic       event_press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int NW = PW + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [7:0]    sync1_q, sync2_q;
   logic [7:0]    btn_q, btn_d, toggle;
   logic [CW-1:0] cnt_q [8];
   logic [CW-1:0] cnt_d [8];
   logic [7:0]    pend_q, pend_d, push_sel;
   logic [2:0]    push_key;
   logic          push, pop, full;
   logic [3:0]    mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_q, rd_q;
   logic [NW-1:0] count_q, count_d;
   logic [3:0]    head;

   // Counter runs only while the synchronized level disagrees with the clean one.
   always_comb begin
      toggle = '0;
      for (int i = 0; i < 8; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != btn_q[i]) begin
            if (cnt_q[i] == CNT_LAST) toggle[i] = 1'b1;
            else cnt_d[i] = cnt_q[i] + CW'(1);
         end
      end
      btn_d = btn_q ^ toggle;
   end

   always_comb begin
      push_sel = '0;
      push_key = '0;
      for (int i = 7; i >= 0; i--) begin
         if (pend_q[i]) begin
            push_sel = 8'b1 << i;
            push_key = 3'(i);
         end
      end
      push   = (|pend_q) && (!full || pop);
      // A second toggle before the push cancels the pair.
      pend_d = (pend_q & ~(push ? push_sel : 8'h00)) ^ toggle;
   end

   always_comb begin
      note_idx = '0;
      for (int i = 7; i >= 0; i--) begin
         if (btn_q[i]) note_idx = 3'(i);
      end
   end

   assign note_active = |btn_q;
   assign btn         = btn_q;
   assign full        = (count_q == NW'(FIFO_DEPTH));
   assign event_valid = (count_q != '0);
   assign pop         = event_valid && event_ready;
   assign head        = event_valid ? mem_q[rd_q] : 4'h0;
   assign event_key   = head[3:1];
   assign event_press = head[0];
   assign count_d     = count_q + NW'(push) - NW'(pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         btn_q   <= '0;
         pend_q  <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         btn_q   <= btn_d;
         pend_q  <= pend_d;
         count_q <= count_d;
         for (int i = 0; i < 8; i++) cnt_q[i] <= cnt_d[i];
         if (push) wr_q <= wr_q + PW'(1);
         if (pop) rd_q <= rd_q + PW'(1);
      end
   end

   // Storage needs no reset: the head is masked while the queue is empty.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= {push_key, btn_q[push_key]};
   end

endmodule

// File: tb/tb_key_scanner.sv
// tb_key_scanner: directed scenarios plus random stimulus against a window-based model.
// Model: a key flips once its delayed raw samples disagreed for a full window.
module tb_key_scanner;

   localparam int DEB   = 4;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] btn_raw = '0;
   logic [7:0] btn;
   logic       note_active;
   logic [2:0] note_idx;
   logic       event_valid;
   logic       event_ready = 1'b0;
   logic [2:0] event_key;
   logic       event_press;

   int n_vec = 0;
   int n_err = 0;

   key_scanner #(.DEBOUNCE_CYCLES(DEB), .FIFO_DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_raw     (btn_raw),
      .btn         (btn),
      .note_active (note_active),
      .note_idx    (note_idx),
      .event_valid (event_valid),
      .event_ready (event_ready),
      .event_key   (event_key),
      .event_press (event_press)
   );

   always #84 clk = ~clk;

   logic [7:0] hist [64];
   int         m_last [8];
   int         mn;
   logic [7:0] m_btn, m_pend, m_tog;
   logic [3:0] mq [$];
   int         m_psz, m_pk;
   bit         m_pop;

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            mq.delete();
            m_btn  = '0;
            m_pend = '0;
            mn     = 64;
            for (int k = 0; k < 64; k++) hist[k] = '0;
            for (int k = 0; k < 8; k++) m_last[k] = 0;
         end else begin
            mn++;
            for (int i = 0; i < 8; i++) begin
               m_tog[i] = 1'b0;
               if (mn - DEB >= m_last[i]) begin
                  m_tog[i] = 1'b1;
                  for (int m = mn - DEB; m < mn; m++)
                     if (hist[(m - 1) % 64][i] == m_btn[i]) m_tog[i] = 1'b0;
               end
            end
            m_psz = mq.size();
            m_pop = (m_psz != 0) && event_ready;
            m_pk  = -1;
            for (int i = 7; i >= 0; i--) if (m_pend[i]) m_pk = i;
            if (m_pop) void'(mq.pop_front());
            if (m_pk >= 0 && (m_psz < DEPTH || m_pop)) begin
               mq.push_back({3'(m_pk), m_btn[m_pk]});
               m_pend[m_pk] = 1'b0;
            end
            m_pend = m_pend ^ m_tog;
            m_btn  = m_btn ^ m_tog;
            for (int i = 0; i < 8; i++) if (m_tog[i]) m_last[i] = mn;
            hist[mn % 64] = btn_raw;
         end
      end
   end

   logic [3:0] got [$];

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      btn_raw = '0;
      event_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic collect(input int cycles);
      got.delete();
      for (int k = 0; k < cycles; k++) begin
         if (event_valid && event_ready) got.push_back({event_key, event_press});
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      btn_raw = 8'hFF;
      repeat (3) @(negedge clk);
      n_vec++;
      if (btn !== 8'h00) begin n_err++; $display("FAIL rst_btn got %h exp 00", btn); end
      n_vec++;
      if (note_active !== 1'b0) begin n_err++; $display("FAIL rst_active got %b exp 0", note_active); end
      n_vec++;
      if (note_idx !== 3'd0) begin n_err++; $display("FAIL rst_idx got %0d exp 0", note_idx); end
      n_vec++;
      if (event_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b exp 0", event_valid); end
      n_vec++;
      if ({event_key, event_press} !== 4'h0) begin
         n_err++; $display("FAIL rst_head got %h exp 0", {event_key, event_press});
      end
      btn_raw = '0;
      rst_n = 1'b1;
   endtask

   task automatic test_single_press();
      do_reset();
      event_ready = 1'b1;
      btn_raw = 8'h01;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         if (k == 5) begin
            n_vec++;
            if (btn !== 8'h00) begin n_err++; $display("FAIL single_early got %h exp 00", btn); end
         end
         if (k == 6) begin
            n_vec++;
            if (btn !== 8'h01) begin n_err++; $display("FAIL single_btn got %h exp 01", btn); end
            n_vec++;
            if ({note_active, note_idx} !== 4'b1000) begin
               n_err++; $display("FAIL single_note got %b/%0d exp 1/0", note_active, note_idx);
            end
            n_vec++;
            if (event_valid !== 1'b0) begin n_err++; $display("FAIL single_bypass got %b exp 0", event_valid); end
         end
         if (k == 7) begin
            n_vec++;
            if ({event_valid, event_key, event_press} !== 5'b1_000_1) begin
               n_err++;
               $display("FAIL single_event got v%b k%0d p%b exp v1 k0 p1", event_valid, event_key, event_press);
            end
         end
      end
   endtask

   task automatic test_glitch();
      do_reset();
      event_ready = 1'b1;
      btn_raw = 8'h20;
      repeat (3) @(negedge clk);
      btn_raw = 8'h00;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         n_vec++;
         if (btn !== 8'h00 || event_valid !== 1'b0) begin
            n_err++; $display("FAIL glitch got btn %h v%b exp 00 v0", btn, event_valid);
         end
      end
   endtask

   task automatic test_multi();
      int cyc [$];
      logic [3:0] exp_ev [3];
      exp_ev[0] = 4'b000_1;
      exp_ev[1] = 4'b010_1;
      exp_ev[2] = 4'b111_1;
      got.delete();
      do_reset();
      event_ready = 1'b1;
      btn_raw = 8'h85;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k == 6) begin
            n_vec++;
            if (btn !== 8'h85 || note_idx !== 3'd0) begin
               n_err++; $display("FAIL multi_btn got %h/%0d exp 85/0", btn, note_idx);
            end
         end
         if (event_valid) begin
            got.push_back({event_key, event_press});
            cyc.push_back(k);
         end
      end
      n_vec++;
      if (got.size() != 3) begin
         n_err++; $display("FAIL multi_count got %0d exp 3", got.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (got[i] !== exp_ev[i] || cyc[i] != 7 + i) begin
               n_err++;
               $display("FAIL multi_ev%0d got %h@%0d exp %h@%0d", i, got[i], cyc[i], exp_ev[i], 7 + i);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      btn_raw = 8'h3F;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (k >= 7) begin
            n_vec++;
            if ({event_valid, event_key, event_press} !== 5'b1_000_1) begin
               n_err++;
               $display("FAIL stall_head got v%b k%0d p%b exp v1 k0 p1", event_valid, event_key, event_press);
            end
         end
      end
      event_ready = 1'b1;
      collect(12);
      n_vec++;
      if (got.size() != 6) begin
         n_err++; $display("FAIL drain_count got %0d exp 6", got.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            n_vec++;
            if (got[i] !== {3'(i), 1'b1}) begin
               n_err++; $display("FAIL drain_ev%0d got %h exp %h", i, got[i], {3'(i), 1'b1});
            end
         end
      end
   endtask

   task automatic test_full_cancel();
      do_reset();
      btn_raw = 8'h0F;
      repeat (12) @(negedge clk);
      btn_raw = 8'h4F;
      repeat (8) @(negedge clk);
      n_vec++;
      if (btn !== 8'h4F) begin n_err++; $display("FAIL cancel_press got %h exp 4f", btn); end
      btn_raw = 8'h0F;
      repeat (8) @(negedge clk);
      n_vec++;
      if (btn !== 8'h0F) begin n_err++; $display("FAIL cancel_rel got %h exp 0f", btn); end
      event_ready = 1'b1;
      collect(12);
      n_vec++;
      if (got.size() != 4) begin
         n_err++; $display("FAIL cancel_count got %0d exp 4", got.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (got[i] !== {3'(i), 1'b1}) begin
               n_err++; $display("FAIL cancel_ev%0d got %h exp %h", i, got[i], {3'(i), 1'b1});
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      btn_raw = 8'h03;
      repeat (10) @(negedge clk);
      n_vec++;
      if (event_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre got v%b exp 1", event_valid); end
      btn_raw = 8'h07;
      repeat (3) @(negedge clk);
      #20 rst_n = 1'b0;
      #1;
      n_vec++;
      if ({btn, note_active, note_idx, event_valid, event_key, event_press} !== 17'h0) begin
         n_err++;
         $display("FAIL mid_async got btn %h a%b i%0d v%b k%0d p%b exp all 0",
                  btn, note_active, note_idx, event_valid, event_key, event_press);
      end
      btn_raw = 8'h02;
      @(negedge clk);
      rst_n = 1'b1;
      event_ready = 1'b1;
      collect(14);
      n_vec++;
      if (got.size() != 1 || got[0] !== 4'b001_1) begin
         n_err++;
         $display("FAIL mid_after got n%0d first %h exp n1 first 3", got.size(), got.size() ? got[0] : 4'h0);
      end
   endtask

   task automatic test_random();
      logic [2:0] e_idx;
      do_reset();
      for (int c = 0; c < 800; c++) begin
         @(negedge clk);
         e_idx = '0;
         for (int i = 7; i >= 0; i--) if (m_btn[i]) e_idx = 3'(i);
         n_vec++;
         if (btn !== m_btn) begin n_err++; $display("FAIL rnd_btn c%0d got %h exp %h", c, btn, m_btn); end
         n_vec++;
         if (note_active !== (|m_btn) || note_idx !== e_idx) begin
            n_err++;
            $display("FAIL rnd_note c%0d got %b/%0d exp %b/%0d", c, note_active, note_idx, |m_btn, e_idx);
         end
         n_vec++;
         if (event_valid !== (mq.size() != 0)) begin
            n_err++; $display("FAIL rnd_valid c%0d got %b exp %b", c, event_valid, mq.size() != 0);
         end
         if (mq.size() != 0) begin
            n_vec++;
            if ({event_key, event_press} !== mq[0]) begin
               n_err++; $display("FAIL rnd_head c%0d got %h exp %h", c, {event_key, event_press}, mq[0]);
            end
         end
         if ($urandom_range(0, 5) == 0) btn_raw = btn_raw ^ (8'h01 << $urandom_range(0, 7));
         if (c >= 300 && c < 380) event_ready = 1'b0;
         else event_ready = ($urandom_range(0, 3) != 0);
      end
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_glitch();
      test_multi();
      test_back_to_back();
      test_full_cancel();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
